// File: rtl/regbank_pkg.sv
// regbank_pkg: register-bank geometry shared by the writeback arbiter and its users
package regbank_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 18;
    localparam int REG_FP    = 16;
    localparam int REG_SP    = 17;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic logic idx_legal(input reg_idx_t idx);
        return 32'(idx) < NUM_REGS;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; REGBANK_WB_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant
);
`ifdef REGBANK_WB_ARBITER_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset, i_advance};
    // lowest requesting index wins
    always_comb begin
        o_grant = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (i_req[k]) o_grant = NREQ'(1) << k;
    end
`else
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] r_ptr, w_next;
    int            w_j;
    // scan from the pointer with wrap-around; the first requester met wins and the pointer moves past it
    always_comb begin
        o_grant = '0;
        w_next  = r_ptr;
        w_j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = (int'(r_ptr) + k) % NREQ;
            if (i_req[PW'(w_j)]) begin
                o_grant = NREQ'(1) << w_j;
                w_next  = (w_j == NREQ - 1) ? '0 : PW'(w_j + 1);
            end
        end
    end
    // pointer only moves when a grant is taken
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_ptr <= '0;
        else if (i_advance) r_ptr <= w_next;
`endif
endmodule

// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: shares the register-bank write port among writeback requesters with a busy scoreboard; option REGBANK_WB_ARBITER_FIXED_PRIO_EN
module regbank_wb_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rsv_valid,
    input  logic [IDX_W-1:0]       rsv_idx,
    output logic                   rsv_ready,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*IDX_W-1:0]  req_idx,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   wr_en,
    output logic [IDX_W-1:0]       wr_idx,
    output logic [DATA_W-1:0]      wr_data,
    output logic [NUM_REGS-1:0]    busy,
    output logic                   err
);
    logic [NUM_REGS-1:0] r_busy, w_set, w_clr;
    logic                r_wr_en, r_err;
    logic [IDX_W-1:0]    r_wr_idx, w_sel_idx;
    logic [DATA_W-1:0]   r_wr_data, w_sel_data;
    logic                w_acc, w_rsv_acc, w_rsv_legal, w_sel_legal;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req_valid),
        .i_advance (w_acc),
        .o_grant   (req_ready)
    );

    assign w_acc       = |req_ready;
    assign w_rsv_legal = idx_legal(reg_idx_t'(rsv_idx));
    assign w_sel_legal = idx_legal(reg_idx_t'(w_sel_idx));
    assign rsv_ready   = !(w_rsv_legal && r_busy[rsv_idx]);
    assign w_rsv_acc   = rsv_valid && rsv_ready;
    assign w_set       = (w_rsv_acc && w_rsv_legal) ? NUM_REGS'(1) << rsv_idx : '0;
    assign w_clr       = (w_acc && w_sel_legal) ? NUM_REGS'(1) << w_sel_idx : '0;

    // steer the granted requester's index and data toward the write port
    always_comb begin
        w_sel_idx  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin
                w_sel_idx  = req_idx[i*IDX_W +: IDX_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
    end

    // registered write port, scoreboard update and sticky error
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_acc && w_sel_legal;
            if (w_acc && w_sel_legal) begin
                r_wr_idx  <= w_sel_idx;
                r_wr_data <= w_sel_data;
            end
            r_busy <= (r_busy | w_set) & ~w_clr;
            if ((w_acc && !(w_sel_legal && r_busy[w_sel_idx])) || (w_rsv_acc && !w_rsv_legal))
                r_err <= 1'b1;
        end

    assign wr_en   = r_wr_en;
    assign wr_idx  = r_wr_idx;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign err     = r_err;
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb_regbank_wb_arbiter: directed table, randomized model comparison and async-reset check for regbank_wb_arbiter
module tb_regbank_wb_arbiter;
    import regbank_pkg::*;
    localparam int NREQ = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rsv_valid = 1'b0;
    logic [4:0]    rsv_idx = '0;
    logic          rsv_ready;
    logic [1:0]    req_valid = '0;
    logic [9:0]    req_idx = '0;
    logic [127:0]  req_data = '0;
    logic [1:0]    req_ready;
    logic          wr_en;
    logic [4:0]    wr_idx;
    logic [63:0]   wr_data;
    logic [17:0]   busy;
    logic          err;

    int checks = 0;
    int failures = 0;

    regbank_wb_arbiter #(.NREQ(NREQ), .DATA_W(64), .IDX_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .rsv_valid (rsv_valid),
        .rsv_idx   (rsv_idx),
        .rsv_ready (rsv_ready),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rv;
        logic [4:0]  ri;
        logic [1:0]  qv;
        logic [4:0]  qi0, qi1;
        logic [63:0] d0, d1;
        bit          e_rr;
        logic [1:0]  e_g;
        bit          e_wen;
        logic [4:0]  e_widx;
        logic [63:0] e_wd;
        logic [17:0] e_busy;
        bit          e_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input bit rv, input logic [4:0] ri, input logic [1:0] qv,
                         input logic [4:0] qi0, input logic [4:0] qi1,
                         input logic [63:0] d0, input logic [63:0] d1);
        rsv_valid = rv;
        rsv_idx   = ri;
        req_valid = qv;
        req_idx   = {qi1, qi0};
        req_data  = {d1, d0};
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    logic [17:0] m_busy;
    int          m_ptr;
    bit          m_err, m_wen;
    logic [4:0]  m_widx;
    logic [63:0] m_wd;

    function automatic logic [4:0] pick_idx();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 5));
    endfunction

    initial begin
        bit          rv, e_rr;
        logic [4:0]  ri, qi0, qi1, qi;
        logic [1:0]  qv;
        logic [63:0] d0, d1, gd;
        int          g, c;

        #1;
        chk("reset.wr_en", 64'(wr_en), 64'h0);
        chk("reset.wr_idx", 64'(wr_idx), 64'h0);
        chk("reset.wr_data", wr_data, 64'h0);
        chk("reset.busy", 64'(busy), 64'h0);
        chk("reset.err", 64'(err), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        tbl[0]  = '{1'b1, 1'b1, 5'd3,  2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 18'h00008, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'd3,  2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b0, 2'b00, 1'b0, 5'd0, 64'h0, 18'h00008, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0,  2'b01, 5'd3,  5'd0,  64'hDEAD_BEEF, 64'h0, 1'b1, 2'b01, 1'b1, 5'd3, 64'hDEAD_BEEF, 18'h0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 5'd5,  2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 18'h00020, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 5'd16, 2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 18'h10020, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0,  2'b11, 5'd5,  5'd16, 64'h1111, 64'h2222, 1'b1, 2'b01, 1'b1, 5'd5, 64'h1111, 18'h10000, 1'b0};
`ifdef REGBANK_WB_ARBITER_FIXED_PRIO_EN
        tbl[6]  = '{1'b0, 1'b0, 5'd0,  2'b11, 5'd5,  5'd16, 64'h1111, 64'h2222, 1'b1, 2'b01, 1'b1, 5'd5, 64'h1111, 18'h10000, 1'b1};
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
`else
        tbl[6]  = '{1'b0, 1'b0, 5'd0,  2'b11, 5'd5,  5'd16, 64'h1111, 64'h2222, 1'b1, 2'b10, 1'b1, 5'd16, 64'h2222, 18'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0,  2'b11, 5'd5,  5'd16, 64'h1111, 64'h2222, 1'b1, 2'b01, 1'b1, 5'd5, 64'h1111, 18'h0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 5'd0,  2'b11, 5'd5,  5'd16, 64'h1111, 64'h2222, 1'b1, 2'b10, 1'b1, 5'd16, 64'h2222, 18'h0, 1'b1};
`endif
        tbl[9]  = '{1'b1, 1'b0, 5'd0,  2'b01, 5'd20, 5'd0,  64'h3333, 64'h0, 1'b1, 2'b01, 1'b0, 5'd0, 64'h0, 18'h0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 18'h0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 5'd17, 2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 18'h20000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 5'd17, 2'b01, 5'd17, 5'd0,  64'h4444, 64'h0, 1'b0, 2'b01, 1'b1, 5'd17, 64'h4444, 18'h0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 5'd17, 2'b00, 5'd0,  5'd0,  64'h0, 64'h0, 1'b1, 2'b00, 1'b0, 5'd17, 64'h4444, 18'h20000, 1'b0};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) pulse_reset();
            apply(tbl[i].rv, tbl[i].ri, tbl[i].qv, tbl[i].qi0, tbl[i].qi1, tbl[i].d0, tbl[i].d1);
            #3;
            chk($sformatf("v%0d.rsv_ready", i), 64'(rsv_ready), 64'(tbl[i].e_rr));
            chk($sformatf("v%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].e_g));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.wr_en", i), 64'(wr_en), 64'(tbl[i].e_wen));
            chk($sformatf("v%0d.wr_idx", i), 64'(wr_idx), 64'(tbl[i].e_widx));
            chk($sformatf("v%0d.wr_data", i), wr_data, tbl[i].e_wd);
            chk($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("v%0d.err", i), 64'(err), 64'(tbl[i].e_err));
        end

        pulse_reset();
        m_busy = '0; m_ptr = 0; m_err = 0; m_wen = 0; m_widx = '0; m_wd = '0;
        for (int n = 0; n < 400; n++) begin
            rv  = 1'($urandom_range(0, 1));
            ri  = pick_idx();
            qv  = 2'($urandom_range(0, 3));
            qi0 = pick_idx();
            qi1 = pick_idx();
            d0  = {$urandom, $urandom};
            d1  = {$urandom, $urandom};
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (g < 0 && qv[c]) g = c;
            end
            qi = (g == 1) ? qi1 : qi0;
            gd = (g == 1) ? d1 : d0;
            if (g >= 0 && qi == ri) rv = 1'b0;
            e_rr = !(ri < 5'd18 && m_busy[ri]);
            apply(rv, ri, qv, qi0, qi1, d0, d1);
            #3;
            chk("rnd.rsv_ready", 64'(rsv_ready), 64'(e_rr));
            chk("rnd.req_ready", 64'(req_ready), (g < 0) ? 64'h0 : 64'(1) << g);
            @(posedge clk);
            #1;
            m_wen = 1'b0;
            if (g >= 0) begin
                if (qi < 5'd18) begin
                    m_wen  = 1'b1;
                    m_widx = qi;
                    m_wd   = gd;
                    if (!m_busy[qi]) m_err = 1'b1;
                    m_busy[qi] = 1'b0;
                end else m_err = 1'b1;
`ifndef REGBANK_WB_ARBITER_FIXED_PRIO_EN
                m_ptr = (g + 1) % NREQ;
`endif
            end
            if (rv && e_rr) begin
                if (ri < 5'd18) m_busy[ri] = 1'b1;
                else m_err = 1'b1;
            end
            chk("rnd.wr_en", 64'(wr_en), 64'(m_wen));
            chk("rnd.wr_idx", 64'(wr_idx), 64'(m_widx));
            chk("rnd.wr_data", wr_data, m_wd);
            chk("rnd.busy", 64'(busy), 64'(m_busy));
            chk("rnd.err", 64'(err), 64'(m_err));
        end

        pulse_reset();
        for (int n = 0; n < 18; n++) begin
            apply(1'b1, 5'(n), 2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
            @(posedge clk);
            #1;
        end
        apply(1'b0, 5'd0, 2'b01, 5'd0, 5'd0, 64'h5555, 64'h0);
        @(posedge clk);
        #1;
        apply(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0);
        chk("pre_async.wr_en", 64'(wr_en), 64'h1);
        chk("pre_async.busy", 64'(busy), 64'h3FFFE);
        #2;
        reset = 1'b0;
        #1;
        chk("async.wr_en", 64'(wr_en), 64'h0);
        chk("async.wr_idx", 64'(wr_idx), 64'h0);
        chk("async.wr_data", wr_data, 64'h0);
        chk("async.busy", 64'(busy), 64'h0);
        chk("async.err", 64'(err), 64'h0);
        #5;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
